preemption_controller: RTL

PREEMPTION_CONTROLLER -- requirements
Module: preemption_controller

---
 rtl/galetron_pkg.sv | 31 +++
 rtl/quantum_timer.sv | 49 ++++
 rtl/preemption_controller.sv | 128 ++++++++++++
 3 files changed

// File: rtl/galetron_pkg.sv
// Shared opcode constants, controller state encoding and the safe-point decode
// helper used by both the preemption controller and the instruction decoder.
package galetron_pkg;

  localparam logic [5:0] OP_JUMP         = 6'b010101;
  localparam logic [5:0] OP_JUMPR        = 6'b100011;
  localparam logic [5:0] OP_LOADR        = 6'b100001;
  localparam logic [5:0] OP_PBRANCH      = 6'b011111;
  localparam logic [5:0] OP_BRANCHZ      = 6'b010011;
  localparam logic [5:0] OP_BRANCHN      = 6'b010100;
  localparam logic [5:0] OP_START_SYSTEM = 6'b100111;

  typedef enum logic [1:0] {
    ST_RUN_OS     = 2'd0,
    ST_RUN_USER   = 2'd1,
    ST_PENDING    = 2'd2,
    ST_RESET_HOLD = 2'd3
  } pc_state_e;

  // Control-flow opcodes leave the pipeline mid-redirect, so nothing may interrupt them.
  function automatic logic is_safe_op(input logic [5:0] op);
    logic safe;
    case (op)
      OP_JUMP, OP_JUMPR, OP_LOADR,
      OP_PBRANCH, OP_BRANCHZ, OP_BRANCHN: safe = 1'b0;
      default:                            safe = 1'b1;
    endcase
    return safe;
  endfunction

endpackage

// File: rtl/quantum_timer.sv
// Time-slice down-counter: loadable, clearable, saturating at zero, with a
// registered one-cycle pulse on the 1 -> 0 transition.
module quantum_timer
  import galetron_pkg::*;
#(
  parameter int QUANTUM_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load,
  input  logic [QUANTUM_WIDTH-1:0] load_value,
  input  logic                     clear,
  input  logic                     enable,
  output logic                     expired
);

  logic [QUANTUM_WIDTH-1:0] count_q, count_d;
  logic                     expired_q, expired_d;

  // Next count: a load beats a clear so a slice programmed during reset hold survives.
  always_comb begin
    count_d   = count_q;
    expired_d = 1'b0;
    if (load) begin
      count_d = load_value;
    end else if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '0)) begin
      count_d   = count_q - QUANTUM_WIDTH'(1);
      expired_d = (count_q == QUANTUM_WIDTH'(1));
    end else begin
      count_d = count_q;
    end
  end

  // Counter and expiry pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/preemption_controller.sv
// Preemption / CPU-restart controller: tracks OS vs user execution, defers
// time-slice preemption and restart requests to safe opcodes, times resetCPU.
module preemption_controller
  import galetron_pkg::*;
#(
  parameter int OP_WIDTH      = 6,
  parameter int PC_WIDTH      = 12,
  parameter int OS_LIMIT      = 256,
  parameter int QUANTUM_WIDTH = 16,
  parameter int RESET_CYCLES  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [OP_WIDTH-1:0]      operation,
  input  logic [PC_WIDTH-1:0]      program_counter,
  input  logic                     system_reset,
  input  logic                     resume_os,
  input  logic [QUANTUM_WIDTH-1:0] quantum,
  input  logic                     quantum_load,
  input  logic                     context_exchange,
  output logic                     resetCPU,
  output logic                     jump_context_exchange,
  output logic                     preempt_pending,
  output logic                     quantum_expired
);

  localparam logic [3:0]  HOLD_INIT  = 4'(RESET_CYCLES - 1);
  localparam logic [31:0] OS_LIMIT_U = 32'(OS_LIMIT);

  pc_state_e  state_q;
  logic [3:0] hold_cnt_q;
  logic       sticky_q, reset_cpu_q, jce_q, pending_q;

  logic [5:0] op_s;
  logic       op_safe_s, start_sys_s, in_os_s, req_s, take_reset_s;
  logic       timer_en_s, timer_expired_s;

  assign op_s         = 6'(operation);
  assign op_safe_s    = is_safe_op(op_s);
  assign start_sys_s  = (op_s == OP_START_SYSTEM);
  assign in_os_s      = (32'(program_counter) < OS_LIMIT_U);
  assign req_s        = system_reset | (resume_os & in_os_s) | sticky_q;
  assign take_reset_s = start_sys_s | ((state_q != ST_RESET_HOLD) & req_s & op_safe_s);
  assign timer_en_s   = (state_q == ST_RUN_USER);

  quantum_timer #(.QUANTUM_WIDTH(QUANTUM_WIDTH)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (quantum_load),
    .load_value (quantum),
    .clear      (take_reset_s),
    .enable     (timer_en_s),
    .expired    (timer_expired_s)
  );

  // Controller FSM with registered strobes; a taken restart overrides every other event.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN_OS;
      hold_cnt_q  <= 4'd0;
      sticky_q    <= 1'b0;
      reset_cpu_q <= 1'b0;
      jce_q       <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      reset_cpu_q <= 1'b0;
      jce_q       <= 1'b0;
      pending_q   <= 1'b0;
      if (take_reset_s) begin
        state_q     <= ST_RESET_HOLD;
        hold_cnt_q  <= HOLD_INIT;
        sticky_q    <= 1'b0;
        reset_cpu_q <= 1'b1;
      end else begin
        if (state_q != ST_RESET_HOLD) begin
          sticky_q <= req_s;
        end else begin
          sticky_q <= 1'b0;
        end
        case (state_q)
          ST_RUN_OS: begin
            if (!in_os_s) state_q <= ST_RUN_USER;
            else          state_q <= ST_RUN_OS;
          end
          ST_RUN_USER: begin
            if (timer_expired_s && context_exchange) begin
              if (op_safe_s) begin
                jce_q   <= 1'b1;
                state_q <= ST_RUN_OS;
              end else begin
                pending_q <= 1'b1;
                state_q   <= ST_PENDING;
              end
            end else if (in_os_s) begin
              state_q <= ST_RUN_OS;
            end else begin
              state_q <= ST_RUN_USER;
            end
          end
          ST_PENDING: begin
            if (op_safe_s) begin
              jce_q   <= 1'b1;
              state_q <= ST_RUN_OS;
            end else begin
              pending_q <= 1'b1;
              state_q   <= ST_PENDING;
            end
          end
          ST_RESET_HOLD: begin
            if (hold_cnt_q == 4'd0) begin
              state_q <= ST_RUN_OS;
            end else begin
              hold_cnt_q  <= hold_cnt_q - 4'd1;
              reset_cpu_q <= 1'b1;
            end
          end
          default: state_q <= ST_RUN_OS;
        endcase
      end
    end
  end

  assign resetCPU              = reset_cpu_q;
  assign jump_context_exchange = jce_q;
  assign preempt_pending       = pending_q;
  assign quantum_expired       = timer_expired_s;

endmodule
